conv_job_scheduler: RTL and testbench

Sequences a list of binary-convolution jobs through the single XNOR convolution engine, which runs one image per `dut_run` pulse. Per job it fetches a 3-word descriptor (input base, output base, weight base) from a descriptor memory, pulses the engine's run input, and waits for its busy signal to fall. While a job runs it relocates the engine's job-relative SRAM and weight-memory addresses by the job's base addresses. It sits between the host control logic and the engine, so several images can be processed back-to-back without host intervention.

---
 rtl/conv_job_scheduler.sv | 174 +++++++++++++++++
 tb/tb_conv_job_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_job_scheduler.sv
// Batch sequencer for the XNOR convolution engine: fetches per-job descriptors,
// launches the engine, watches its busy line and relocates its memory addresses.
module conv_job_scheduler #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16,
   parameter int CNT_W  = 5,
   parameter int TO_W   = 16
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic              start,
   input  logic [CNT_W-1:0]  job_count,
   input  logic [ADDR_W-1:0] desc_base,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [CNT_W-1:0]  jobs_done,
   output logic [ADDR_W-1:0] desc_read_address,
   input  logic [DATA_W-1:0] desc_read_data,
   output logic              eng_run,
   input  logic              eng_busy,
   input  logic [ADDR_W-1:0] eng_sram_read_address,
   input  logic [ADDR_W-1:0] eng_sram_write_address,
   input  logic [ADDR_W-1:0] eng_wmem_read_address,
   input  logic              eng_sram_write_enable,
   output logic [ADDR_W-1:0] sram_read_address,
   output logic [ADDR_W-1:0] sram_write_address,
   output logic [ADDR_W-1:0] wmem_read_address,
   output logic              sram_write_enable
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LAUNCH, S_WAIT_BUSY, S_RUN, S_NEXT, S_DONE
   } state_t;

   // WAIT_BUSY gives up after LAUNCH plus 15 idle cycles (16 cycles after eng_run).
   localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(14);
   localparam logic [TO_W-1:0] RUN_LAST  = {{(TO_W-1){1'b1}}, 1'b0};

   state_t            state_q, state_d;
   logic [1:0]        sub_q, sub_d;
   logic [TO_W-1:0]   wdog_q, wdog_d;
   logic [CNT_W-1:0]  job_count_q, job_count_d;
   logic [ADDR_W-1:0] desc_base_q, desc_base_d;
   logic [CNT_W-1:0]  jobs_done_q, jobs_done_d;
   logic [ADDR_W-1:0] in_base_q, in_base_d, out_base_q, out_base_d, w_base_q, w_base_d;
   logic              busy_q, busy_d, done_q, done_d, error_q, error_d, eng_run_q, eng_run_d;
   logic [ADDR_W-1:0] desc_addr_q, desc_addr_d;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q     <= S_IDLE;
         sub_q       <= '0;
         wdog_q      <= '0;
         job_count_q <= '0;
         desc_base_q <= '0;
         jobs_done_q <= '0;
         in_base_q   <= '0;
         out_base_q  <= '0;
         w_base_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         eng_run_q   <= 1'b0;
         desc_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         sub_q       <= sub_d;
         wdog_q      <= wdog_d;
         job_count_q <= job_count_d;
         desc_base_q <= desc_base_d;
         jobs_done_q <= jobs_done_d;
         in_base_q   <= in_base_d;
         out_base_q  <= out_base_d;
         w_base_q    <= w_base_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         eng_run_q   <= eng_run_d;
         desc_addr_q <= desc_addr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sub_d       = sub_q;
      wdog_d      = wdog_q;
      job_count_d = job_count_q;
      desc_base_d = desc_base_q;
      jobs_done_d = jobs_done_q;
      in_base_d   = in_base_q;
      out_base_d  = out_base_q;
      w_base_d    = w_base_q;
      error_d     = error_q;
      case (state_q)
         S_IDLE: if (start) begin
            job_count_d = job_count;
            desc_base_d = desc_base;
            error_d     = 1'b0;
            jobs_done_d = '0;
            sub_d       = '0;
            state_d     = (job_count == '0) ? S_DONE : S_FETCH;
         end
         S_FETCH: begin
            // Read latency 1: word k arrives in sub-cycle k+1.
            sub_d = sub_q + 2'd1;
            case (sub_q)
               2'd1:    in_base_d  = ADDR_W'(desc_read_data);
               2'd2:    out_base_d = ADDR_W'(desc_read_data);
               2'd3:    w_base_d   = ADDR_W'(desc_read_data);
               default: ;
            endcase
            if (sub_q == 2'd3) state_d = S_LAUNCH;
         end
         S_LAUNCH: begin
            wdog_d  = '0;
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (eng_busy) begin
               wdog_d  = '0;
               state_d = S_RUN;
            end else if (wdog_q == WAIT_LAST) begin
               error_d = 1'b1;
               state_d = S_DONE;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         S_RUN: begin
            if (!eng_busy) begin
               state_d = S_NEXT;
            end else if (wdog_q == RUN_LAST) begin
               error_d = 1'b1;
               state_d = S_DONE;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         S_NEXT: begin
            jobs_done_d = jobs_done_q + 1'b1;
            sub_d       = '0;
            state_d     = (jobs_done_d == job_count_q) ? S_DONE : S_FETCH;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Control outputs are decoded from the next state so they are registered
   // yet line up with the state they describe.
   always_comb begin
      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_DONE);
      eng_run_d   = (state_d == S_LAUNCH);
      desc_addr_d = desc_addr_q;
      if (state_d == S_FETCH && sub_d != 2'd3)
         desc_addr_d = desc_base_d + ADDR_W'({jobs_done_d, 2'b00}) + ADDR_W'(sub_d);
   end

   assign busy              = busy_q;
   assign done              = done_q;
   assign error             = error_q;
   assign eng_run           = eng_run_q;
   assign jobs_done         = jobs_done_q;
   assign desc_read_address = desc_addr_q;

   assign sram_read_address  = in_base_q  + eng_sram_read_address;
   assign sram_write_address = out_base_q + eng_sram_write_address;
   assign wmem_read_address  = w_base_q   + eng_wmem_read_address;
   assign sram_write_enable  = eng_sram_write_enable &
                               (state_q == S_LAUNCH || state_q == S_WAIT_BUSY || state_q == S_RUN);

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Directed bench for conv_job_scheduler: descriptor memory and engine models,
// a relocation vector table and hand-timed multi-job / error / reset sequences.
module tb_conv_job_scheduler;

   logic        clk, reset_b, start;
   logic [4:0]  job_count, jobs_done;
   logic [11:0] desc_base, desc_read_address;
   logic [15:0] desc_read_data;
   logic        busy, done, error, eng_run, eng_busy;
   logic [11:0] eng_sram_read_address, eng_sram_write_address, eng_wmem_read_address;
   logic        eng_sram_write_enable, sram_write_enable;
   logic [11:0] sram_read_address, sram_write_address, wmem_read_address;

   conv_job_scheduler dut (
      .clk(clk), .reset_b(reset_b), .start(start), .job_count(job_count),
      .desc_base(desc_base), .busy(busy), .done(done), .error(error),
      .jobs_done(jobs_done), .desc_read_address(desc_read_address),
      .desc_read_data(desc_read_data), .eng_run(eng_run), .eng_busy(eng_busy),
      .eng_sram_read_address(eng_sram_read_address),
      .eng_sram_write_address(eng_sram_write_address),
      .eng_wmem_read_address(eng_wmem_read_address),
      .eng_sram_write_enable(eng_sram_write_enable),
      .sram_read_address(sram_read_address), .sram_write_address(sram_write_address),
      .wmem_read_address(wmem_read_address), .sram_write_enable(sram_write_enable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Descriptor memory, one-cycle read latency.
   logic [15:0] dmem [0:4095];
   always @(posedge clk) desc_read_data <= dmem[desc_read_address];

   // Engine model: BUSY_LEN cycles from its run pulse until busy is first low.
   int   busy_len = 40;
   logic model_en = 1'b1;
   int   ecnt;
   always @(posedge clk or negedge reset_b)
      if (!reset_b)                ecnt <= 0;
      else if (model_en && eng_run) ecnt <= busy_len - 1;
      else if (ecnt != 0)           ecnt <= ecnt - 1;
   assign eng_busy = (ecnt != 0);

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int s = 0;
   int run_log[$], done_log[$], addr_log[$];
   int done_jobs, done_err;
   logic [11:0] prev_addr = '0;
   always @(negedge clk) begin
      if (reset_b) begin
         if (eng_run) run_log.push_back(cyc - s);
         if (done) begin
            done_log.push_back(cyc - s);
            done_jobs = int'(jobs_done);
            done_err  = int'(error);
         end
         if (desc_read_address != prev_addr) addr_log.push_back(int'(desc_read_address));
      end
      prev_addr = desc_read_address;
   end

   int n_cmp = 0, n_err = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_list(input string nm, input int got[$], input int exp[$]);
      chk({nm, "_len"}, got.size(), exp.size());
      foreach (exp[i]) chk(nm, (i < got.size()) ? got[i] : -1, exp[i]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_b = 1'b0;
      repeat (2) @(negedge clk);
      reset_b = 1'b1;
   endtask

   // Edge 0 samples start; returns at the negedge inside cycle 1.
   task automatic launch(input int n, input int base);
      @(negedge clk);
      job_count = 5'(n);
      desc_base = 12'(base);
      start     = 1'b1;
      s         = cyc;
      run_log.delete(); done_log.delete(); addr_log.delete();
      done_jobs = -1; done_err = -1;
      @(negedge clk);
      start     = 1'b0;
      job_count = 5'd7;
      desc_base = 12'hABC;
   endtask

   task automatic wait_rel(input int r);
      while (cyc - s < r) @(negedge clk);
   endtask

   typedef struct {
      logic [11:0] rd, wr, wm;
      logic        we;
      logic [11:0] xrd, xwr, xwm;
      logic        xwe;
   } vec_t;
   vec_t tbl [4];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      // Bases for the single-job table are in=0x000, out=0x200, w=0x001.
      tbl[0] = '{12'h010, 12'h003, 12'h020, 1'b1, 12'h010, 12'h203, 12'h021, 1'b1};
      tbl[1] = '{12'hFFF, 12'hE00, 12'hFFF, 1'b0, 12'hFFF, 12'h000, 12'h000, 1'b0};
      tbl[2] = '{12'h000, 12'h000, 12'h000, 1'b1, 12'h000, 12'h200, 12'h001, 1'b1};
      tbl[3] = '{12'h7A5, 12'h1FF, 12'h3C0, 1'b1, 12'h7A5, 12'h3FF, 12'h3C1, 1'b1};

      foreach (dmem[i]) dmem[i] = '0;
      dmem['h100] = 16'h000; dmem['h101] = 16'h200; dmem['h102] = 16'h001;
      reset_b = 1'b0; start = 1'b0; job_count = '0; desc_base = '0;
      eng_sram_read_address = 12'h123; eng_sram_write_address = 12'h456;
      eng_wmem_read_address = 12'h789; eng_sram_write_enable = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_eng_run", eng_run, 0);
      chk("rst_jobs_done", jobs_done, 0);
      chk("rst_desc_addr", desc_read_address, 0);
      chk("rst_sram_rd", sram_read_address, 'h123);
      chk("rst_sram_wr", sram_write_address, 'h456);
      chk("rst_wmem_rd", wmem_read_address, 'h789);
      reset_b = 1'b1;
      eng_sram_read_address = '0; eng_sram_write_address = '0; eng_wmem_read_address = '0;

      // Single job, engine busy 40
      busy_len = 40;
      launch(1, 'h100);
      chk("single_busy_c1", busy, 1);
      wait_rel(10);
      foreach (tbl[i]) begin
         eng_sram_read_address  = tbl[i].rd;
         eng_sram_write_address = tbl[i].wr;
         eng_wmem_read_address  = tbl[i].wm;
         eng_sram_write_enable  = tbl[i].we;
         #1;
         chk($sformatf("tbl%0d_sram_rd", i), sram_read_address, tbl[i].xrd);
         chk($sformatf("tbl%0d_sram_wr", i), sram_write_address, tbl[i].xwr);
         chk($sformatf("tbl%0d_wmem_rd", i), wmem_read_address, tbl[i].xwm);
         chk($sformatf("tbl%0d_we", i), sram_write_enable, tbl[i].xwe);
      end
      eng_sram_read_address = '0; eng_sram_write_address = '0;
      eng_wmem_read_address = '0; eng_sram_write_enable = 1'b0;
      wait_rel(47);
      chk("single_busy_done", busy, 1);
      wait_rel(48);
      chk("single_busy_fall", busy, 0);
      chk_list("single_run", run_log, '{5});
      chk_list("single_done", done_log, '{47});
      chk("single_jobs", done_jobs, 1);
      chk("single_err", done_err, 0);
      chk_list("single_desc", addr_log, '{'h100, 'h101, 'h102});

      // Three jobs back-to-back, engine busy 20
      dmem['h100] = 16'h000; dmem['h101] = 16'h300; dmem['h102] = 16'h010;
      dmem['h104] = 16'h040; dmem['h105] = 16'h340; dmem['h106] = 16'h020;
      dmem['h108] = 16'h080; dmem['h109] = 16'h380; dmem['h10A] = 16'h030;
      do_reset();
      busy_len = 20;
      launch(3, 'h100);
      wait_rel(34);
      chk("three_in_base1", sram_read_address, 'h040);
      chk("three_w_base1", wmem_read_address, 'h020);
      wait_rel(60);
      chk("three_in_base2", sram_read_address, 'h080);
      chk("three_out_base2", sram_write_address, 'h380);
      wait_rel(82);
      chk_list("three_run", run_log, '{5, 31, 57});
      chk_list("three_done", done_log, '{79});
      chk("three_jobs", done_jobs, 3);
      chk_list("three_desc", addr_log,
               '{'h100, 'h101, 'h102, 'h104, 'h105, 'h106, 'h108, 'h109, 'h10A});

      // Zero jobs
      do_reset();
      launch(0, 'h100);
      chk("zero_busy_c1", busy, 1);
      wait_rel(5);
      chk_list("zero_done", done_log, '{1});
      chk("zero_runs", run_log.size(), 0);
      chk("zero_desc_reads", addr_log.size(), 0);
      chk("zero_jobs", done_jobs, 0);

      // Engine never responds
      model_en = 1'b0;
      launch(1, 'h100);
      wait_rel(25);
      chk_list("hang_run", run_log, '{5});
      chk_list("hang_done", done_log, '{21});
      chk("hang_err_at_done", done_err, 1);
      chk("hang_err_sticky", error, 1);
      chk("hang_jobs", jobs_done, 0);
      model_en = 1'b1;
      busy_len = 10;
      launch(1, 'h100);
      chk("hang_err_cleared", error, 0);
      wait_rel(20);
      chk_list("recover_done", done_log, '{17});
      chk("recover_err", done_err, 0);

      // Relocation wrap and write gating
      dmem['h200] = 16'h000; dmem['h201] = 16'hFFE; dmem['h202] = 16'h000;
      do_reset();
      eng_sram_write_address = 12'h003;
      eng_sram_write_enable  = 1'b1;
      launch(1, 'h200);
      wait_rel(2);
      chk("gate_fetch_we", sram_write_enable, 0);
      wait_rel(5);
      chk("gate_launch_run", eng_run, 1);
      chk("wrap_sram_wr", sram_write_address, 'h001);
      chk("gate_launch_we", sram_write_enable, 1);
      wait_rel(17);
      chk("gate_done_pulse", done, 1);
      chk("gate_done_we", sram_write_enable, 0);
      eng_sram_write_address = '0;
      eng_sram_write_enable  = 1'b0;
      wait_rel(19);

      // Reset during RUN of job 2 of 3, then a clean rerun
      do_reset();
      busy_len = 20;
      eng_sram_read_address = 12'h055;
      launch(3, 'h100);
      wait_rel(40);
      chk("mid_busy_before", busy, 1);
      reset_b = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_jobs", jobs_done, 0);
      chk("mid_rst_desc", desc_read_address, 0);
      chk("mid_rst_sram_rd", sram_read_address, 'h055);
      chk("mid_rst_error", error, 0);
      repeat (2) @(negedge clk);
      reset_b = 1'b1;
      eng_sram_read_address = '0;
      launch(3, 'h100);
      wait_rel(82);
      chk_list("rerun_run", run_log, '{5, 31, 57});
      chk_list("rerun_done", done_log, '{79});
      chk("rerun_jobs", done_jobs, 3);
      chk("rerun_first_desc", (addr_log.size() > 0) ? addr_log[0] : -1, 'h100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
